// File: rtl/seq_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_serial_tx
// Description : Serial bit-stream transmitter feeding a sequence detector.
//               Accepts a WIDTH-bit word on a valid/ready handshake in IDLE,
//               then shifts it out MSB first on bit_out. After the frame it
//               inserts GAP idle cycles. All outputs are registered.
//               Optional macro SEQ_TX_PREAMBLE_EN adds a PRE state that
//               emits the sync pattern 1,0,1,0 before the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serial_tx #(
  parameter int WIDTH = 8,   // data word width, 2..32
  parameter int GAP   = 2    // idle cycles after each frame, 0..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int               CNT_W      = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);
  localparam logic [3:0]       C_GAP_LEN  = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
`ifdef SEQ_TX_PREAMBLE_EN
    S_PRE   = 2'b01,
`endif
    S_SHIFT = 2'b10,
    S_GAP   = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;     // word being shifted, MSB is next bit
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // data bits left, including current
  logic [3:0]         gcnt_q, gcnt_d;     // gap cycles left, including current
`ifdef SEQ_TX_PREAMBLE_EN
  logic [1:0]         pcnt_q, pcnt_d;     // index of preamble bit on the line
`endif

  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic frame_done_q, frame_done_d;
  logic busy_q, busy_d;
  logic ready_q, ready_d;

  // Next-state logic: handshake in IDLE, frame sequencing, gap timing.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
`ifdef SEQ_TX_PREAMBLE_EN
    pcnt_d  = pcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          sreg_d = data_in;
`ifdef SEQ_TX_PREAMBLE_EN
          state_d = S_PRE;
          pcnt_d  = 2'd0;
`else
          state_d = S_SHIFT;
          cnt_d   = C_CNT_FULL;
`endif
        end
      end
`ifdef SEQ_TX_PREAMBLE_EN
      S_PRE: begin
        if (pcnt_q == 2'd3) begin
          state_d = S_SHIFT;
          cnt_d   = C_CNT_FULL;
          pcnt_d  = 2'd0;
        end else begin
          pcnt_d = pcnt_q + 2'd1;
        end
      end
`endif
      S_SHIFT: begin
        // After WIDTH shifts the register has drained to all zeros.
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == C_CNT_LAST) begin
          cnt_d = '0;
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gcnt_d  = C_GAP_LEN;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_LAST;
        end
      end
      S_GAP: begin
        if (gcnt_q <= 4'd1) begin
          state_d = S_IDLE;
          gcnt_d  = 4'd0;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output can be driven straight from a flop.
  always_comb begin
    bit_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      S_SHIFT: begin
        bit_out_d    = sreg_d[WIDTH-1];
        bit_valid_d  = 1'b1;
        frame_done_d = (cnt_d == C_CNT_LAST);
      end
`ifdef SEQ_TX_PREAMBLE_EN
      S_PRE: begin
        bit_out_d   = ~pcnt_d[0];
        bit_valid_d = 1'b1;
      end
`endif
      default: begin
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset is asynchronous so a frame aborts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      gcnt_q       <= '0;
`ifdef SEQ_TX_PREAMBLE_EN
      pcnt_q       <= '0;
`endif
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
`ifdef SEQ_TX_PREAMBLE_EN
      pcnt_q       <= pcnt_d;
`endif
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;

endmodule
`default_nettype wire

// File: doc/seq_serial_tx.md
SEQ_SERIAL_TX -- requirements
Module: seq_serial_tx

Interface
REQ-001 The block SHALL be a serial bit-stream transmitter that drives the single-bit input of a serial sequence detector.
REQ-002 Parameter WIDTH SHALL default to 8 and set the data word width; legal values are 2..32.
REQ-003 Parameter GAP SHALL default to 2 and set the idle cycles inserted after each frame; legal values are 0..15.
REQ-004 Port clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 Port data_in  input  WIDTH  SHALL carry the word to transmit.
REQ-007 Port data_valid  input  1  SHALL indicate that data_in holds a word to send.
REQ-008 Port data_ready  output  1  SHALL indicate that the block can accept a word.
REQ-009 Port bit_out  output  1  SHALL carry the serial bit stream, registered.
REQ-010 Port bit_valid  output  1  SHALL be high on every cycle in which bit_out carries a frame bit.
REQ-011 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-012 Port frame_done  output  1  SHALL pulse for one cycle, coincident with the last data bit on bit_out.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, SHIFT and GAP; state PRE SHALL exist only under REQ-029.
REQ-014 data_ready SHALL be high only in IDLE; a transfer SHALL occur on a rising edge where data_valid and data_ready are both high.
REQ-015 On a transfer, data_in SHALL be captured into a WIDTH-bit shift register; later changes to data_in SHALL be ignored until the next transfer.
REQ-016 On the same edge as the transfer, the FSM SHALL enter SHIFT (or PRE), and bit_out/bit_valid SHALL present the first bit in the following cycle (one-cycle latency).
REQ-017 SHIFT SHALL emit the data MSB first, one bit per cycle, for exactly WIDTH cycles, with bit_valid=1 throughout.
REQ-018 A down-counter of width clog2(WIDTH)+1 SHALL track the remaining bits; frame_done SHALL assert while the counter indicates the last bit.
REQ-019 After the last bit, the FSM SHALL enter GAP for GAP cycles with bit_out=0 and bit_valid=0, then return to IDLE.
REQ-020 If GAP=0, the FSM SHALL go directly from SHIFT to IDLE.
REQ-021 In IDLE, bit_out SHALL be 0 and bit_valid SHALL be 0.
REQ-022 In IDLE, data_valid=0 SHALL leave the FSM in IDLE with no output activity.
REQ-023 Throughput SHALL be one word per (WIDTH + GAP + 1) cycles when data_valid is held high (plus 4 cycles under REQ-029).
REQ-024 data_valid SHALL be ignored in every state other than IDLE, and no word SHALL be lost or double-sent.
REQ-025 An unreachable state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-026 When rst is asserted, the FSM SHALL go to IDLE immediately, without waiting for a clock edge; bit_out, bit_valid, frame_done and busy SHALL be 0; data_ready SHALL be 1; the shift register and counters SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, and no remaining bits SHALL be emitted after release.
REQ-028 After rst deasserts, the first transfer SHALL be accepted on the first rising edge with data_valid=1.

Configuration
REQ-029 Macro SEQ_TX_PREAMBLE_EN, when defined, SHALL add state PRE, which emits the 4-bit sync pattern 1,0,1,0 (bit_valid=1, frame_done=0) before SHIFT; undefined, transfers SHALL go straight to SHIFT and no PRE logic SHALL be built.

Verification
REQ-030 Scenario 1: WIDTH=8, GAP=2, no macro, transfer 0xA5 -> bit_out 1,0,1,0,0,1,0,1 on cycles 1..8 after the transfer; frame_done on cycle 8 only; bit_valid 0 on cycles 9-10; data_ready=1 on cycle 11.
REQ-031 Scenario 2: data_valid held high with words 0xFF then 0x00 -> 0xFF and 0x00 are each sent exactly once, with 11 cycles between transfers, and data_in changes during SHIFT have no effect.
REQ-032 Scenario 3: GAP=0, words 0x0F then 0xF0 back-to-back -> 16 data bits with exactly one IDLE cycle between the frames.
REQ-033 Scenario 4: rst pulsed after 3 bits of 0xC3 -> outputs go to their reset values immediately, no further bits are emitted, and a new transfer of 0x81 sends 1,0,0,0,0,0,0,1.
REQ-034 Scenario 5: SEQ_TX_PREAMBLE_EN defined, transfer 0x3C -> 1,0,1,0 then 0,0,1,1,1,1,0,0; frame_done on the 12th bit; a downstream 1010 detector flags the preamble.
